// File: rtl/ysyx_24100006_axi_sram_slave_if.sv
// AXI4 bus bundle between the crossbar's SRAM-side master port and the SRAM responder.
// The signal names keep the s_axi_ prefix so that they match the crossbar netlist.
interface ysyx_24100006_axi_sram_slave_if;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;

  modport slave (
    input  s_axi_awvalid, s_axi_awaddr, s_axi_awlen, s_axi_awsize,
    input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
    input  s_axi_bready,
    input  s_axi_arvalid, s_axi_araddr, s_axi_arlen, s_axi_arsize,
    input  s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
    output s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_rlast
  );

  modport master (
    output s_axi_awvalid, s_axi_awaddr, s_axi_awlen, s_axi_awsize,
    output s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
    output s_axi_bready,
    output s_axi_arvalid, s_axi_araddr, s_axi_arlen, s_axi_arsize,
    output s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
    input  s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_rlast
  );
endinterface

// File: rtl/ysyx_24100006_axi_sram_slave.sv
// AXI4 SRAM responder: word-organised storage with independent read and write FSMs,
// INCR bursts, byte strobes, programmable latency, and SLVERR for out-of-range beats.
//
// state  | meaning
// R_IDLE | arready high, waiting for an AR handshake
// R_WAIT | latency countdown before the next R beat
// R_DATA | rvalid high, beat held until rready
// W_IDLE | awready high, waiting for an AW handshake
// W_DATA | wready high, accepting W beats
// W_WAIT | latency countdown after the final W beat
// W_RESP | bvalid high until bready
module ysyx_24100006_axi_sram_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          RD_LAT     = 2,
  parameter int          WR_LAT     = 1
) (
  input logic clk,
  input logic reset,
  ysyx_24100006_axi_sram_slave_if.slave axi
);
  localparam int               CNT_W    = 16;
  localparam logic [CNT_W-1:0] RD_FIRST = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] RD_NEXT  = CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);
  localparam logic [CNT_W-1:0] WR_FIRST = CNT_W'((WR_LAT > 0) ? WR_LAT - 1 : 0);
  localparam logic [32:0]      MEM_LO   = {1'b0, BASE_ADDR};
  localparam logic [32:0]      MEM_HI   = MEM_LO + (33'd4 << DEPTH_LOG2);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  // 33-bit compare so a window ending exactly at 2^32 still works
  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} >= MEM_LO) && ({1'b0, a} < MEM_HI);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] a);
    return DEPTH_LOG2'((a - BASE_ADDR) >> 2);
  endfunction

  function automatic logic [2:0] eff_size(input logic [2:0] s);
    return (s > 3'd2) ? 3'd2 : s;
  endfunction

  function automatic logic [31:0] fetch(input logic [31:0] a);
    return in_range(a) ? mem[word_idx(a)] : 32'd0;
  endfunction

  // ---------------- read channel ----------------
  r_state_t         r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr;
  logic [7:0]       r_len;
  logic [7:0]       r_beat;
  logic [2:0]       r_size;
  logic             arready_q;
  logic             rvalid_q;
  logic             rlast_q;
  logic             r_err;
  logic [31:0]      rdata_q;
  logic [31:0]      r_next;
  logic [7:0]       r_beat_next;

  assign r_next      = r_addr + (32'd1 << r_size);
  assign r_beat_next = r_beat + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= R_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_size    <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      r_err     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (axi.s_axi_arvalid && arready_q) begin
            arready_q <= 1'b0;
            r_addr    <= axi.s_axi_araddr;
            r_len     <= axi.s_axi_arlen;
            r_size    <= eff_size(axi.s_axi_arsize);
            r_beat    <= '0;
            r_cnt     <= RD_FIRST;
            r_state   <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_cnt == '0) begin
            rvalid_q <= 1'b1;
            rdata_q  <= fetch(r_addr);
            r_err    <= !in_range(r_addr);
            rlast_q  <= (r_beat == r_len);
            r_state  <= R_DATA;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        R_DATA: begin
          if (axi.s_axi_rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state   <= R_IDLE;
            end else begin
              r_addr <= r_next;
              r_beat <= r_beat_next;
              // single-cycle latency streams the next beat without dropping rvalid
              if (RD_LAT == 1) begin
                rdata_q <= fetch(r_next);
                r_err   <= !in_range(r_next);
                rlast_q <= (r_beat_next == r_len);
              end else begin
                rvalid_q <= 1'b0;
                r_cnt    <= RD_NEXT;
                r_state  <= R_WAIT;
              end
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- write channel ----------------
  w_state_t         w_state;
  logic [CNT_W-1:0] w_cnt;
  logic [31:0]      w_addr;
  logic [7:0]       w_len;
  logic [7:0]       w_beat;
  logic [2:0]       w_size;
  logic             awready_q;
  logic             wready_q;
  logic             bvalid_q;
  logic             w_err_acc;
  logic             b_err;
  logic             w_hs;
  logic             w_addr_ok;
  logic             w_is_last;
  logic             w_beat_err;

  assign w_hs       = axi.s_axi_wvalid && wready_q;
  assign w_addr_ok  = in_range(w_addr);
  assign w_is_last  = (w_beat == w_len);
  assign w_beat_err = !w_addr_ok || (axi.s_axi_wlast != w_is_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state   <= W_IDLE;
      w_cnt     <= '0;
      w_addr    <= '0;
      w_len     <= '0;
      w_beat    <= '0;
      w_size    <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      w_err_acc <= 1'b0;
      b_err     <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (axi.s_axi_awvalid && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_addr    <= axi.s_axi_awaddr;
            w_len     <= axi.s_axi_awlen;
            w_size    <= eff_size(axi.s_axi_awsize);
            w_beat    <= '0;
            w_err_acc <= 1'b0;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_addr <= w_addr + (32'd1 << w_size);
            w_beat <= w_beat + 8'd1;
            if (w_beat_err) w_err_acc <= 1'b1;
            // the beat count, not wlast, ends the burst
            if (w_is_last) begin
              wready_q <= 1'b0;
              if (WR_LAT == 0) begin
                bvalid_q <= 1'b1;
                b_err    <= w_err_acc || w_beat_err;
                w_state  <= W_RESP;
              end else begin
                w_cnt   <= WR_FIRST;
                w_state <= W_WAIT;
              end
            end
          end
        end
        W_WAIT: begin
          if (w_cnt == '0) begin
            bvalid_q <= 1'b1;
            b_err    <= w_err_acc;
            w_state  <= W_RESP;
          end else begin
            w_cnt <= w_cnt - 1'b1;
          end
        end
        W_RESP: begin
          if (axi.s_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // storage is never reset; a write in the same cycle as a read of that word is seen next cycle
  always_ff @(posedge clk) begin
    if (w_hs && w_addr_ok && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (axi.s_axi_wstrb[i]) mem[word_idx(w_addr)][8*i +: 8] <= axi.s_axi_wdata[8*i +: 8];
      end
    end
  end

  assign axi.s_axi_awready = awready_q;
  assign axi.s_axi_wready  = wready_q;
  assign axi.s_axi_bvalid  = bvalid_q;
  assign axi.s_axi_bresp   = b_err ? 2'b10 : 2'b00;
  assign axi.s_axi_arready = arready_q;
  assign axi.s_axi_rvalid  = rvalid_q;
  assign axi.s_axi_rdata   = rdata_q;
  assign axi.s_axi_rresp   = r_err ? 2'b10 : 2'b00;
  assign axi.s_axi_rlast   = rlast_q;
endmodule

// File: tb/tb_ysyx_24100006_axi_sram_slave.sv
// Self-checking bench for the AXI SRAM responder: directed scenarios plus randomized
// bursts compared against a byte-level storage model.
module tb_ysyx_24100006_axi_sram_slave;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          DEPTH  = 4096;
  localparam int          RD_LAT = 2;
  localparam int          WR_LAT = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ysyx_24100006_axi_sram_slave_if axi ();

  ysyx_24100006_axi_sram_slave #(
    .BASE_ADDR (BASE),
    .DEPTH_LOG2(12),
    .RD_LAT    (RD_LAT),
    .WR_LAT    (WR_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .axi  (axi)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wr_data   [256];
  logic [3:0]  wr_strb   [256];
  logic [31:0] rd_data_q [256];
  logic [1:0]  rd_resp_q [256];
  logic        rd_last_q [256];

  logic [31:0] mdl_mem [DEPTH];
  logic [3:0]  mdl_kn  [DEPTH];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_in_range(input logic [31:0] a);
    logic [63:0] x;
    x = {32'd0, a};
    return (x >= {32'd0, BASE}) && (x < {32'd0, BASE} + 64'(DEPTH * 4));
  endfunction

  function automatic logic [31:0] m_beat_addr(input logic [31:0] s, input int i, input logic [2:0] sz);
    int b;
    b = (sz > 3'd2) ? 2 : int'(sz);
    return s + 32'(i * (1 << b));
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] s, input int len, input logic [2:0] sz,
                                              input int last_at);
    bit err;
    err = (last_at != len);
    for (int i = 0; i <= len; i++) begin
      logic [31:0] a;
      a = m_beat_addr(s, i, sz);
      if (m_in_range(a)) begin
        int idx;
        idx = int'((a - BASE) >> 2);
        for (int j = 0; j < 4; j++) begin
          if (wr_strb[i][j]) begin
            mdl_mem[idx][8*j +: 8] = wr_data[i][8*j +: 8];
            mdl_kn[idx][j] = 1'b1;
          end
        end
      end else begin
        err = 1'b1;
      end
    end
    return err ? 2'b10 : 2'b00;
  endfunction

  task automatic m_expect(input logic [31:0] a, output logic [31:0] d, output logic [31:0] m,
                          output logic [1:0] r);
    if (m_in_range(a)) begin
      int idx;
      idx = int'((a - BASE) >> 2);
      d = mdl_mem[idx];
      for (int j = 0; j < 4; j++) m[8*j +: 8] = {8{mdl_kn[idx][j]}};
      r = 2'b00;
    end else begin
      d = 32'd0;
      m = 32'hFFFF_FFFF;
      r = 2'b10;
    end
  endtask

  // ---------------- bus drivers ----------------
  task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] size, input int last_at,
                          output logic [1:0] resp, output bit to);
    int n;
    to = 1'b0;
    axi.s_axi_awvalid = 1'b1;
    axi.s_axi_awaddr  = addr;
    axi.s_axi_awlen   = 8'(len);
    axi.s_axi_awsize  = size;
    n = 0;
    while (!axi.s_axi_awready && n < 50) begin tick(); n++; end
    if (n >= 50) to = 1'b1;
    tick();
    axi.s_axi_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      axi.s_axi_wvalid = 1'b1;
      axi.s_axi_wdata  = wr_data[i];
      axi.s_axi_wstrb  = wr_strb[i];
      axi.s_axi_wlast  = (i == last_at);
      n = 0;
      while (!axi.s_axi_wready && n < 50) begin tick(); n++; end
      if (n >= 50) to = 1'b1;
      tick();
    end
    axi.s_axi_wvalid = 1'b0;
    axi.s_axi_wlast  = 1'b0;
    axi.s_axi_bready = 1'b1;
    n = 0;
    while (!axi.s_axi_bvalid && n < 50) begin tick(); n++; end
    if (n >= 50) to = 1'b1;
    resp = axi.s_axi_bresp;
    tick();
    axi.s_axi_bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                         input int stall_beat, input int stall_cyc,
                         output int lat, output int nbeats, output bit stable, output bit to);
    int n;
    logic [31:0] v;
    to = 1'b0;
    stable = 1'b1;
    nbeats = 0;
    axi.s_axi_arvalid = 1'b1;
    axi.s_axi_araddr  = addr;
    axi.s_axi_arlen   = 8'(len);
    axi.s_axi_arsize  = size;
    n = 0;
    while (!axi.s_axi_arready && n < 50) begin tick(); n++; end
    if (n >= 50) to = 1'b1;
    tick();
    axi.s_axi_arvalid = 1'b0;
    axi.s_axi_rready  = 1'b1;
    n = 0;
    while (!axi.s_axi_rvalid && n < 50) begin tick(); n++; end
    lat = n;
    for (int b = 0; b <= len; b++) begin
      n = 0;
      while (!axi.s_axi_rvalid && n < 50) begin tick(); n++; end
      if (n >= 50) begin to = 1'b1; break; end
      if (b == stall_beat) begin
        axi.s_axi_rready = 1'b0;
        v = axi.s_axi_rdata;
        for (int k = 0; k < stall_cyc; k++) begin
          tick();
          if (!axi.s_axi_rvalid || axi.s_axi_rdata !== v) stable = 1'b0;
        end
        axi.s_axi_rready = 1'b1;
      end
      rd_data_q[b] = axi.s_axi_rdata;
      rd_resp_q[b] = axi.s_axi_rresp;
      rd_last_q[b] = axi.s_axi_rlast;
      nbeats++;
      tick();
    end
    axi.s_axi_rready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_tests++;
    if ({axi.s_axi_awready, axi.s_axi_arready, axi.s_axi_wready, axi.s_axi_bvalid, axi.s_axi_rvalid,
         axi.s_axi_rlast} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: aw/ar/w/b/r/last got %b want 000000",
               {axi.s_axi_awready, axi.s_axi_arready, axi.s_axi_wready, axi.s_axi_bvalid,
                axi.s_axi_rvalid, axi.s_axi_rlast});
    end
    n_tests++;
    if ({axi.s_axi_bresp, axi.s_axi_rresp, axi.s_axi_rdata} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_data: bresp %b rresp %b rdata %h want zeros", axi.s_axi_bresp,
               axi.s_axi_rresp, axi.s_axi_rdata);
    end
    reset = 1'b0;
    n_tests++;
    if (axi.s_axi_arready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_ready: arready got %b want 0", axi.s_axi_arready);
    end
    tick();
    n_tests++;
    if ({axi.s_axi_awready, axi.s_axi_arready} !== 2'b11) begin
      n_fail++;
      $display("FAIL ready_after_reset: aw/ar got %b want 11", {axi.s_axi_awready, axi.s_axi_arready});
    end
  endtask

  task automatic test_single();
    logic [1:0] resp, exp_b, er;
    logic [31:0] ed, em;
    bit to, stable;
    int lat, nb;
    wr_data[0] = 32'hDEAD_BEEF;
    wr_strb[0] = 4'hF;
    exp_b = model_write(32'h8000_0010, 0, 3'd2, 0);
    do_write(32'h8000_0010, 0, 3'd2, 0, resp, to);
    n_tests++;
    if (to || resp !== exp_b) begin
      n_fail++;
      $display("FAIL single_bresp: got %b (timeout %0d) want %b", resp, to, exp_b);
    end
    do_read(32'h8000_0010, 0, 3'd2, -1, 0, lat, nb, stable, to);
    n_tests++;
    if (to || lat != RD_LAT || nb != 1) begin
      n_fail++;
      $display("FAIL single_latency: lat %0d beats %0d timeout %0d want lat %0d beats 1", lat, nb, to, RD_LAT);
    end
    m_expect(32'h8000_0010, ed, em, er);
    n_tests++;
    if (rd_data_q[0] !== ed || rd_resp_q[0] !== er || rd_last_q[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_read: data %h resp %b last %b want %h %b 1", rd_data_q[0], rd_resp_q[0],
               rd_last_q[0], ed, er);
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp, exp_b, er;
    logic [31:0] ed, em;
    bit to, stable;
    int lat, nb;
    wr_data[0] = 32'h0000_1200;
    wr_strb[0] = 4'b0010;
    exp_b = model_write(32'h8000_0010, 0, 3'd2, 0);
    do_write(32'h8000_0010, 0, 3'd2, 0, resp, to);
    do_read(32'h8000_0010, 0, 3'd2, -1, 0, lat, nb, stable, to);
    m_expect(32'h8000_0010, ed, em, er);
    n_tests++;
    if (to || resp !== exp_b || rd_data_q[0] !== ed) begin
      n_fail++;
      $display("FAIL strobe_merge: data %h bresp %b want %h %b", rd_data_q[0], resp, ed, exp_b);
    end
  endtask

  task automatic test_burst();
    logic [1:0] resp, exp_b, er;
    logic [31:0] ed, em;
    logic [3:0] lasts;
    bit to, stable;
    int lat, nb;
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'(i + 1); wr_strb[i] = 4'hF; end
    exp_b = model_write(32'h8000_0100, 3, 3'd2, 3);
    do_write(32'h8000_0100, 3, 3'd2, 3, resp, to);
    n_tests++;
    if (to || resp !== exp_b) begin
      n_fail++;
      $display("FAIL burst_bresp: got %b want %b", resp, exp_b);
    end
    do_read(32'h8000_0100, 3, 3'd2, 1, 3, lat, nb, stable, to);
    n_tests++;
    if (to || nb != 4 || stable !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_stall_hold: beats %0d stable %0d timeout %0d want 4 1 0", nb, stable, to);
    end
    lasts = 4'b0;
    for (int b = 0; b < 4; b++) begin
      m_expect(m_beat_addr(32'h8000_0100, b, 3'd2), ed, em, er);
      lasts[b] = rd_last_q[b];
      n_tests++;
      if (rd_data_q[b] !== ed || rd_resp_q[b] !== er) begin
        n_fail++;
        $display("FAIL burst_beat%0d: data %h resp %b want %h %b", b, rd_data_q[b], rd_resp_q[b], ed, er);
      end
    end
    n_tests++;
    if (lasts !== 4'b1000) begin
      n_fail++;
      $display("FAIL burst_rlast: got %b want 1000", lasts);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp, exp_b, er;
    logic [31:0] ed, em;
    bit to, stable;
    int lat, nb;
    do_read(32'h7FFF_FFFC, 0, 3'd2, -1, 0, lat, nb, stable, to);
    m_expect(32'h7FFF_FFFC, ed, em, er);
    n_tests++;
    if (to || rd_resp_q[0] !== er || rd_data_q[0] !== ed) begin
      n_fail++;
      $display("FAIL oor_read: resp %b data %h want %b %h", rd_resp_q[0], rd_data_q[0], er, ed);
    end
    wr_data[0] = 32'h1234_5678; wr_strb[0] = 4'hF;
    exp_b = model_write(BASE, 0, 3'd2, 0);
    do_write(BASE, 0, 3'd2, 0, resp, to);
    wr_data[0] = 32'hBAD0_BAD0; wr_strb[0] = 4'hF;
    exp_b = model_write(32'h9000_0000, 0, 3'd2, 0);
    do_write(32'h9000_0000, 0, 3'd2, 0, resp, to);
    n_tests++;
    if (to || resp !== exp_b) begin
      n_fail++;
      $display("FAIL oor_bresp: got %b want %b", resp, exp_b);
    end
    // a beat at the last word followed by one past the top
    wr_data[0] = 32'hCAFE_0001; wr_data[1] = 32'hCAFE_0002; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
    exp_b = model_write(BASE + 32'(DEPTH * 4 - 4), 1, 3'd2, 1);
    do_write(BASE + 32'(DEPTH * 4 - 4), 1, 3'd2, 1, resp, to);
    n_tests++;
    if (to || resp !== exp_b) begin
      n_fail++;
      $display("FAIL top_cross_bresp: got %b want %b", resp, exp_b);
    end
    do_read(BASE + 32'(DEPTH * 4 - 4), 1, 3'd2, -1, 0, lat, nb, stable, to);
    for (int b = 0; b < 2; b++) begin
      m_expect(m_beat_addr(BASE + 32'(DEPTH * 4 - 4), b, 3'd2), ed, em, er);
      n_tests++;
      if (to || rd_data_q[b] !== ed || rd_resp_q[b] !== er) begin
        n_fail++;
        $display("FAIL top_cross_beat%0d: data %h resp %b want %h %b", b, rd_data_q[b], rd_resp_q[b], ed, er);
      end
    end
    do_read(BASE, 0, 3'd2, -1, 0, lat, nb, stable, to);
    m_expect(BASE, ed, em, er);
    n_tests++;
    if (to || rd_data_q[0] !== ed || rd_resp_q[0] !== er) begin
      n_fail++;
      $display("FAIL oor_storage_unchanged: data %h want %h", rd_data_q[0], ed);
    end
  endtask

  task automatic test_wlast_err();
    logic [1:0] resp, exp_b, er;
    logic [31:0] ed, em;
    bit to, stable;
    int lat, nb;
    wr_data[0] = 32'hA5A5_0000; wr_data[1] = 32'hA5A5_0001; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
    exp_b = model_write(32'h8000_0200, 1, 3'd2, 0);
    do_write(32'h8000_0200, 1, 3'd2, 0, resp, to);
    n_tests++;
    if (to || resp !== exp_b) begin
      n_fail++;
      $display("FAIL wlast_early: bresp %b timeout %0d want %b", resp, to, exp_b);
    end
    do_read(32'h8000_0200, 1, 3'd2, -1, 0, lat, nb, stable, to);
    for (int b = 0; b < 2; b++) begin
      m_expect(m_beat_addr(32'h8000_0200, b, 3'd2), ed, em, er);
      n_tests++;
      if (to || rd_data_q[b] !== ed) begin
        n_fail++;
        $display("FAIL wlast_early_data%0d: got %h want %h", b, rd_data_q[b], ed);
      end
    end
    exp_b = model_write(32'h8000_0208, 1, 3'd2, -1);
    do_write(32'h8000_0208, 1, 3'd2, -1, resp, to);
    n_tests++;
    if (to || resp !== exp_b) begin
      n_fail++;
      $display("FAIL wlast_missing: bresp %b want %b", resp, exp_b);
    end
    exp_b = model_write(32'h8000_0208, 1, 3'd2, 1);
    do_write(32'h8000_0208, 1, 3'd2, 1, resp, to);
    n_tests++;
    if (to || resp !== exp_b) begin
      n_fail++;
      $display("FAIL error_not_sticky_across_bursts: bresp %b want %b", resp, exp_b);
    end
  endtask

  task automatic test_random();
    logic [1:0] resp, exp_b, er;
    logic [31:0] ed, em, start;
    logic [2:0] sz;
    bit to, stable;
    int lat, nb, len;
    for (int it = 0; it < 20; it++) begin
      len = $urandom_range(0, 7);
      sz  = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) start = BASE + 32'(DEPTH * 4 - 16) + 32'($urandom_range(0, 15));
      else start = BASE + 32'($urandom_range(0, DEPTH * 4 - 64));
      for (int i = 0; i <= len; i++) begin
        wr_data[i] = $urandom;
        wr_strb[i] = 4'($urandom_range(0, 15));
      end
      exp_b = model_write(start, len, sz, len);
      do_write(start, len, sz, len, resp, to);
      n_tests++;
      if (to || resp !== exp_b) begin
        n_fail++;
        $display("FAIL rand%0d_bresp: addr %h len %0d size %0d got %b want %b", it, start, len, sz, resp, exp_b);
      end
      do_read(start, len, sz, $urandom_range(0, len), $urandom_range(0, 3), lat, nb, stable, to);
      n_tests++;
      if (to || nb != len + 1 || stable !== 1'b1) begin
        n_fail++;
        $display("FAIL rand%0d_rd_flow: beats %0d stable %0d want %0d 1", it, nb, stable, len + 1);
      end
      for (int b = 0; b <= len && b < nb; b++) begin
        m_expect(m_beat_addr(start, b, sz), ed, em, er);
        n_tests++;
        if ((rd_data_q[b] & em) !== (ed & em) || rd_resp_q[b] !== er || rd_last_q[b] !== (b == len)) begin
          n_fail++;
          $display("FAIL rand%0d_beat%0d: data %h resp %b last %b want %h (mask %h) %b %b", it, b,
                   rd_data_q[b], rd_resp_q[b], rd_last_q[b], ed, em, er, (b == len));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] resp, exp_b, er;
    logic [31:0] ed, em;
    bit wto, rto, stable;
    int lat, nb;
    for (int i = 0; i < 4; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
    fork
      do_write(32'h8000_0400, 3, 3'd2, 3, resp, wto);
      do_read(32'h8000_0100, 3, 3'd2, -1, 0, lat, nb, stable, rto);
    join
    exp_b = model_write(32'h8000_0400, 3, 3'd2, 3);
    n_tests++;
    if (wto || rto || resp !== exp_b || nb != 4) begin
      n_fail++;
      $display("FAIL concurrent_flow: bresp %b beats %0d timeouts %0d/%0d want %b 4", resp, nb, wto, rto, exp_b);
    end
    for (int b = 0; b < 4; b++) begin
      m_expect(m_beat_addr(32'h8000_0100, b, 3'd2), ed, em, er);
      n_tests++;
      if (rd_data_q[b] !== ed || rd_last_q[b] !== (b == 3)) begin
        n_fail++;
        $display("FAIL concurrent_read%0d: data %h last %b want %h %b", b, rd_data_q[b], rd_last_q[b], ed, (b == 3));
      end
    end
    do_read(32'h8000_0400, 3, 3'd2, -1, 0, lat, nb, stable, rto);
    for (int b = 0; b < 4; b++) begin
      m_expect(m_beat_addr(32'h8000_0400, b, 3'd2), ed, em, er);
      n_tests++;
      if (rto || rd_data_q[b] !== ed) begin
        n_fail++;
        $display("FAIL concurrent_write%0d: data %h want %h", b, rd_data_q[b], ed);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] er;
    logic [31:0] ed, em;
    bit to, stable;
    int n, lat, nb;
    axi.s_axi_arvalid = 1'b1;
    axi.s_axi_araddr  = 32'h8000_0100;
    axi.s_axi_arlen   = 8'd3;
    axi.s_axi_arsize  = 3'd2;
    n = 0;
    while (!axi.s_axi_arready && n < 50) begin tick(); n++; end
    tick();
    axi.s_axi_arvalid = 1'b0;
    axi.s_axi_rready  = 1'b1;
    n = 0;
    while (!axi.s_axi_rvalid && n < 50) begin tick(); n++; end
    tick();
    n = 0;
    while (!axi.s_axi_rvalid && n < 50) begin tick(); n++; end
    n_tests++;
    if (axi.s_axi_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL midburst_beat2_valid: rvalid got %b want 1", axi.s_axi_rvalid);
    end
    axi.s_axi_rready = 1'b0;
    reset = 1'b1;
    tick();
    n_tests++;
    if ({axi.s_axi_rvalid, axi.s_axi_arready} !== 2'b00) begin
      n_fail++;
      $display("FAIL midburst_reset: rvalid/arready got %b want 00", {axi.s_axi_rvalid, axi.s_axi_arready});
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if (axi.s_axi_arready !== 1'b1 || axi.s_axi_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL midburst_recover: arready %b rvalid %b want 1 0", axi.s_axi_arready, axi.s_axi_rvalid);
    end
    do_read(32'h8000_0104, 0, 3'd2, -1, 0, lat, nb, stable, to);
    m_expect(32'h8000_0104, ed, em, er);
    n_tests++;
    if (to || lat != RD_LAT || rd_data_q[0] !== ed || rd_last_q[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL midburst_new_read: lat %0d data %h last %b want %0d %h 1", lat, rd_data_q[0],
               rd_last_q[0], RD_LAT, ed);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    axi.s_axi_awvalid = 1'b0; axi.s_axi_awaddr = '0; axi.s_axi_awlen = '0; axi.s_axi_awsize = '0;
    axi.s_axi_wvalid  = 1'b0; axi.s_axi_wdata  = '0; axi.s_axi_wstrb = '0; axi.s_axi_wlast  = 1'b0;
    axi.s_axi_bready  = 1'b0;
    axi.s_axi_arvalid = 1'b0; axi.s_axi_araddr = '0; axi.s_axi_arlen = '0; axi.s_axi_arsize = '0;
    axi.s_axi_rready  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin mdl_mem[i] = '0; mdl_kn[i] = '0; end
    test_reset();
    test_single();
    test_strobe();
    test_burst();
    test_out_of_range();
    test_wlast_err();
    test_random();
    test_back_to_back();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_24100006_axi_sram_slave.md
Name: ysyx_24100006_axi_sram_slave

Overview:
- AXI4 responder (slave) that terminates the crossbar's SRAM-side master port.
- Provides word-organised on-chip storage with independent read and write channel FSMs.
- Supports INCR bursts, byte strobes and programmable access latency.
- Out-of-range accesses get SLVERR, which drives the core's Access Fault path.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- DEPTH_LOG2, 12, storage depth = 2^DEPTH_LOG2 32-bit words.
- RD_LAT, 2, cycles between the AR handshake and the first R beat (≥1); also applied between subsequent beats.
- WR_LAT, 1, cycles between the final W handshake and BVALID (≥0).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_axi_awvalid / s_axi_awready  in / out  1  write address handshake
- s_axi_awaddr  in  32  write start address
- s_axi_awlen  in  8  beats-1
- s_axi_awsize  in  3  log2 bytes per beat (0..2)
- s_axi_wvalid / s_axi_wready  in / out  1  write data handshake
- s_axi_wdata  in  32  write data, lane-aligned
- s_axi_wstrb  in  4  byte enables
- s_axi_wlast  in  1  final write beat marker
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_bresp  out  2  00 OKAY, 10 SLVERR
- s_axi_arvalid / s_axi_arready  in / out  1  read address handshake
- s_axi_araddr  in  32  read start address
- s_axi_arlen  in  8  beats-1
- s_axi_arsize  in  3  log2 bytes per beat
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- s_axi_rdata  out  32  full aligned word
- s_axi_rresp  out  2  00 OKAY, 10 SLVERR
- s_axi_rlast  out  1  final read beat marker

Behaviour:
- Reset: every valid/ready output is 0; bresp, rresp and rdata are 0; rlast is 0; both FSMs return to IDLE. Storage is not cleared. Reset in mid-burst abandons the burst; no response is issued.
- awready and arready are registered. Each is 1 only in its channel's IDLE state, so it first rises the cycle after reset deasserts.
- Read FSM R_IDLE→R_WAIT→R_DATA:
  - R_IDLE: on arvalid&&arready, latch addr, len and size; load the latency counter with RD_LAT-1; go to R_WAIT.
  - R_WAIT: decrement the counter; at 0, drive rvalid=1 and go to R_DATA.
  - R_DATA: rdata = mem[(addr-BASE_ADDR)>>2]. rlast=1 when the beat count equals len. Outputs are held stable while rvalid&&!rready.
  - On handshake: addr += (1<<size). If last, go to R_IDLE; otherwise reload the counter and go to R_WAIT. RD_LAT=1 gives back-to-back beats.
- Write FSM W_IDLE→W_DATA→W_RESP:
  - W_IDLE: on AW handshake, latch addr, len and size; go to W_DATA with wready=1.
  - W_DATA: on each W handshake, write the bytes where wstrb[i]=1 into mem word (addr-BASE_ADDR)>>2, then addr += (1<<size).
  - After len+1 beats: wready=0; wait WR_LAT cycles; go to W_RESP with bvalid=1. bvalid holds until bready, then return to W_IDLE.
- Range check is done per beat: in range iff BASE_ADDR ≤ addr < BASE_ADDR + 4·2^DEPTH_LOG2.
  - Out-of-range read beat: rdata=0, rresp=10.
  - Out-of-range write beat: discarded, and a sticky error sets bresp=10.
- Protocol error: wlast=1 before beat len, or wlast=0 on beat len, gives bresp=10. Beat counting still governs burst end.
- Burst address is computed in 32-bit arithmetic and wraps silently at 2^32. A beat crossing the storage top gets SLVERR.
- arsize>2 or awsize>2 is treated as size 2.
- Read and write channels run concurrently. Read-during-write to the same word in the same cycle returns the old data; the write is visible from the next cycle.
- rresp and bresp are combinational from registered per-beat error flags and change only when the corresponding valid rises or a beat advances.

Test Plan:
- Single write, then read: AW 0x8000_0010, W 0xDEAD_BEEF strb 1111 → bvalid with bresp 00. Then AR 0x8000_0010 len 0 → rvalid exactly RD_LAT cycles after AR, rdata 0xDEAD_BEEF, rlast 1, rresp 00.
- Strobe merge: over 0xDEAD_BEEF, write 0x0000_1200 strb 0010 → readback 0xDEAD_12EF.
- INCR burst: write 4 beats from 0x8000_0100 with data 1,2,3,4, then read len 3. R beats return 1,2,3,4 with rlast only on the 4th. Hold rready=0 for 3 cycles on beat 2: rdata stays 2 and rvalid stays 1.
- Out of range: AR 0x7FFF_FFFC → rresp 10, rdata 0. AW 0x9000_0000 → bresp 10, and a follow-up read shows storage unchanged.
- wlast error: awlen 1 with wlast=1 on beat 0 → 2 beats accepted, bresp 10.
- Reset mid-burst: reset asserted during beat 2 of a 4-beat read → next cycle rvalid 0 and arready 0. arready returns to 1 one cycle after reset deasserts, and a new read succeeds.
